// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared multi-cycle ALU.
// One operation is in flight at a time; each completion is reported with a one-cycle done/err pulse.
module alu_arbiter #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned LAT   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             on,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    input  logic [6:0]       op0,
    input  logic [6:0]       op1,
    output logic [2:0]       alu_in_sel,
    output logic [WIDTH-1:0] alu_num1,
    output logic [WIDTH-1:0] alu_num2,
    output logic [6:0]       alu_out_sel,
    input  logic [WIDTH-1:0] alu_out,
    output logic [1:0]       grant,
    output logic             done0,
    output logic             done1,
    output logic             err,
    output logic [WIDTH-1:0] result,
    output logic [1:0]       currState,
    output logic [1:0]       nextState
);

    localparam int unsigned CW = 4;

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_LOAD = 2'b01;
    localparam logic [1:0] S_EXEC = 2'b10;
    localparam logic [1:0] S_DONE = 2'b11;

    localparam logic [2:0] SEL_PERSIST = 3'b100;
    localparam logic [2:0] SEL_LOAD    = 3'b010;
    localparam logic [2:0] SEL_RESET   = 3'b001;

    logic [1:0]       state_q, state_d;
    logic [1:0]       grant_q, grant_d;
    logic             done0_q, done0_d;
    logic             done1_q, done1_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             last_q, last_d;
    logic [2:0]       in_sel_q, in_sel_d;
    logic [WIDTH-1:0] num1_q, num1_d;
    logic [WIDTH-1:0] num2_q, num2_d;
    logic [6:0]       out_sel_q, out_sel_d;

    logic             pick1;
    logic [6:0]       pick_op;
    logic [WIDTH-1:0] pick_a;
    logic [WIDTH-1:0] pick_b;

    // Round-robin choice: requester 1 wins a tie only if requester 0 was served last.
    always_comb begin
        pick1   = req1 && (!req0 || !last_q);
        pick_op = pick1 ? op1 : op0;
        pick_a  = pick1 ? a1 : a0;
        pick_b  = pick1 ? b1 : b0;
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        done0_d   = 1'b0;
        done1_d   = 1'b0;
        err_d     = 1'b0;
        result_d  = result_q;
        cnt_d     = cnt_q;
        last_d    = last_q;
        in_sel_d  = SEL_PERSIST;
        num1_d    = num1_q;
        num2_d    = num2_q;
        out_sel_d = out_sel_q;

        case (state_q)
            S_IDLE: begin
                if (on && (req0 || req1)) begin
                    grant_d = pick1 ? 2'b10 : 2'b01;
                    if ($onehot(pick_op)) begin
                        num1_d    = pick_a;
                        num2_d    = pick_b;
                        out_sel_d = pick_op;
                        in_sel_d  = SEL_LOAD;
                        state_d   = S_LOAD;
                    end else begin
                        // Malformed opcode bypasses the ALU and completes immediately.
                        err_d    = 1'b1;
                        done0_d  = !pick1;
                        done1_d  = pick1;
                        result_d = '0;
                        state_d  = S_DONE;
                    end
                end
            end
            S_LOAD: begin
                cnt_d   = CW'(LAT - 1);
                state_d = S_EXEC;
            end
            S_EXEC: begin
                if (cnt_q == '0) begin
                    result_d = alu_out;
                    done0_d  = grant_q[0];
                    done1_d  = grant_q[1];
                    state_d  = S_DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                last_d  = grant_q[1];
                grant_d = 2'b00;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            grant_q   <= 2'b00;
            done0_q   <= 1'b0;
            done1_q   <= 1'b0;
            err_q     <= 1'b0;
            result_q  <= '0;
            cnt_q     <= '0;
            last_q    <= 1'b1;
            in_sel_q  <= SEL_RESET;
            num1_q    <= '0;
            num2_q    <= '0;
            out_sel_q <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            done0_q   <= done0_d;
            done1_q   <= done1_d;
            err_q     <= err_d;
            result_q  <= result_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
            in_sel_q  <= in_sel_d;
            num1_q    <= num1_d;
            num2_q    <= num2_d;
            out_sel_q <= out_sel_d;
        end
    end

    assign alu_in_sel  = in_sel_q;
    assign alu_num1    = num1_q;
    assign alu_num2    = num2_q;
    assign alu_out_sel = out_sel_q;
    assign grant       = grant_q;
    assign done0       = done0_q;
    assign done1       = done1_q;
    assign err         = err_q;
    assign result      = result_q;
    assign currState   = state_q;
    assign nextState   = state_d;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: two instances (LAT=1 and LAT=3) share stimulus and are checked
// every cycle against a transaction-timeline model, plus hand-computed spot values.
module tb_alu_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       on = 1'b1;
    logic       req0 = 1'b0;
    logic       req1 = 1'b0;
    logic [7:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic [6:0] op0 = '0, op1 = '0;

    logic [2:0] in_sel_w [2];
    logic [7:0] n1_w [2];
    logic [7:0] n2_w [2];
    logic [6:0] os_w [2];
    logic [7:0] res_w [2];
    logic [7:0] acc [2];
    logic [1:0] grant_w [2];
    logic [1:0] cs_w [2];
    logic [1:0] ns_w [2];
    logic       done0_w [2];
    logic       done1_w [2];
    logic       err_w [2];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(8), .LAT(1)) u_dut0 (
        .clk(clk), .rst(rst), .on(on), .req0(req0), .req1(req1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1), .op0(op0), .op1(op1),
        .alu_in_sel(in_sel_w[0]), .alu_num1(n1_w[0]), .alu_num2(n2_w[0]),
        .alu_out_sel(os_w[0]), .alu_out(acc[0]), .grant(grant_w[0]),
        .done0(done0_w[0]), .done1(done1_w[0]), .err(err_w[0]), .result(res_w[0]),
        .currState(cs_w[0]), .nextState(ns_w[0])
    );

    alu_arbiter #(.WIDTH(8), .LAT(3)) u_dut1 (
        .clk(clk), .rst(rst), .on(on), .req0(req0), .req1(req1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1), .op0(op0), .op1(op1),
        .alu_in_sel(in_sel_w[1]), .alu_num1(n1_w[1]), .alu_num2(n2_w[1]),
        .alu_out_sel(os_w[1]), .alu_out(acc[1]), .grant(grant_w[1]),
        .done0(done0_w[1]), .done1(done1_w[1]), .err(err_w[1]), .result(res_w[1]),
        .currState(cs_w[1]), .nextState(ns_w[1])
    );

    function automatic int lat_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic logic [7:0] alu_fn(input logic [7:0] x, input logic [7:0] y,
                                          input logic [6:0] op);
        if (op[6]) return x + y;
        if (op[5]) return x - y;
        return x ^ y;
    endfunction

    // ALU stub: operands captured on load, result presented until the next load.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++)
            if (in_sel_w[i] == 3'b010) acc[i] <= alu_fn(n1_w[i], n2_w[i], os_w[i]);
    end

    task automatic check(input string name, input int inst, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s inst%0d @%0t: got %0h expected %0h", name, inst, $time, act, exp);
        end
    endtask

    // Model: each accepted request becomes a transaction that reports done m_len edges after its grant.
    bit         m_valid;
    bit         m_busy [2];
    bit         m_owner [2];
    bit         m_bad [2];
    bit         m_last [2];
    bit         m_inrst [2];
    int         m_t [2];
    int         m_len [2];
    logic [7:0] m_sum [2];
    logic [7:0] m_res [2];
    logic [7:0] m_n1 [2];
    logic [7:0] m_n2 [2];
    logic [6:0] m_os [2];

    function automatic bit pick_of(input bit last);
        return req1 && (!req0 || !last);
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_valid = 1'b1;
                m_busy[i] = 1'b0; m_last[i] = 1'b1; m_inrst[i] = 1'b1;
                m_res[i] = '0; m_n1[i] = '0; m_n2[i] = '0; m_os[i] = '0;
                m_t[i] = 0; m_len[i] = 0;
            end else begin
                m_inrst[i] = 1'b0;
                if (m_busy[i]) begin
                    m_t[i]++;
                    if (m_t[i] == m_len[i] + 1) begin
                        m_busy[i] = 1'b0;
                        m_last[i] = m_owner[i];
                    end
                end else if (on && (req0 || req1)) begin
                    logic [6:0] op;
                    m_owner[i] = pick_of(m_last[i]);
                    op = m_owner[i] ? op1 : op0;
                    m_bad[i] = !$onehot(op);
                    m_busy[i] = 1'b1;
                    m_t[i] = 0;
                    m_len[i] = m_bad[i] ? 0 : lat_of(i) + 1;
                    if (!m_bad[i]) begin
                        m_n1[i] = m_owner[i] ? a1 : a0;
                        m_n2[i] = m_owner[i] ? b1 : b0;
                        m_os[i] = op;
                        m_sum[i] = alu_fn(m_n1[i], m_n2[i], op);
                    end
                end
                if (m_busy[i] && m_t[i] == m_len[i]) m_res[i] = m_bad[i] ? 8'h00 : m_sum[i];
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            for (int i = 0; i < 2; i++) begin
                bit         dn;
                logic [1:0] eg, es, en;
                logic [2:0] esel;
                dn   = m_busy[i] && (m_t[i] == m_len[i]);
                eg   = !m_busy[i] ? 2'b00 : (m_owner[i] ? 2'b10 : 2'b01);
                es   = !m_busy[i] ? 2'd0 : dn ? 2'd3 : (m_t[i] == 0) ? 2'd1 : 2'd2;
                esel = m_inrst[i] ? 3'b001 :
                       (m_busy[i] && m_t[i] == 0 && !m_bad[i]) ? 3'b010 : 3'b100;
                check("grant", i, 32'(grant_w[i]), 32'(eg));
                check("done0", i, 32'(done0_w[i]), 32'(dn && !m_owner[i]));
                check("done1", i, 32'(done1_w[i]), 32'(dn && m_owner[i]));
                check("err", i, 32'(err_w[i]), 32'(dn && m_bad[i]));
                check("result", i, 32'(res_w[i]), 32'(m_res[i]));
                check("currState", i, 32'(cs_w[i]), 32'(es));
                check("alu_in_sel", i, 32'(in_sel_w[i]), 32'(esel));
                check("alu_num1", i, 32'(n1_w[i]), 32'(m_n1[i]));
                check("alu_num2", i, 32'(n2_w[i]), 32'(m_n2[i]));
                check("alu_out_sel", i, 32'(os_w[i]), 32'(m_os[i]));
                if (!rst) begin
                    if (!m_busy[i]) begin
                        if (on && (req0 || req1))
                            en = $onehot(pick_of(m_last[i]) ? op1 : op0) ? 2'd1 : 2'd3;
                        else
                            en = 2'd0;
                    end else if (dn) en = 2'd0;
                    else if (m_t[i] + 1 == m_len[i]) en = 2'd3;
                    else en = 2'd2;
                    check("nextState", i, 32'(ns_w[i]), 32'(en));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int inst, input int max);
        for (int c = 0; c < max; c++) begin
            @(negedge clk);
            if (done0_w[inst] || done1_w[inst]) return;
        end
        n_cmp++;
        n_bad++;
        $display("FAIL wait_done inst%0d: no done pulse within %0d cycles", inst, max);
    endtask

    task automatic wait_idle(input int max);
        for (int c = 0; c < max; c++) begin
            @(negedge clk);
            if (cs_w[0] == 2'd0 && cs_w[1] == 2'd0 && !m_busy[0] && !m_busy[1]) return;
        end
        n_cmp++;
        n_bad++;
        $display("FAIL wait_idle: arbiters not idle within %0d cycles", max);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [1:0] exp_g [3];
        logic [7:0] exp_r [3];
        exp_g = '{2'b01, 2'b10, 2'b01};
        exp_r = '{8'd6, 8'd9, 8'd6};

        // Reset for two cycles.
        step(); step();
        check("lit_rst_grant", 0, 32'(grant_w[0]), 32'h0);
        check("lit_rst_insel", 0, 32'(in_sel_w[0]), 32'h1);
        check("lit_rst_state", 0, 32'(cs_w[0]), 32'h0);
        check("lit_rst_result", 0, 32'(res_w[0]), 32'h0);
        rst = 1'b0;
        step();
        check("lit_idle_insel", 0, 32'(in_sel_w[0]), 32'h4);

        // Single add from requester 0: 87 + 26.
        req0 = 1'b1; a0 = 8'd87; b0 = 8'd26; op0 = 7'b1000000;
        step();
        req0 = 1'b0;
        check("lit_load_insel", 0, 32'(in_sel_w[0]), 32'h2);
        check("lit_load_grant", 0, 32'(grant_w[0]), 32'h1);
        wait_done(0, 10);
        check("lit_add_result", 0, 32'(res_w[0]), 32'd113);
        check("lit_add_grant", 0, 32'(grant_w[0]), 32'h1);
        wait_idle(40);

        // Single subtract from requester 1: 50 - 8.
        step();
        req1 = 1'b1; a1 = 8'd50; b1 = 8'd8; op1 = 7'b0100000;
        step();
        req1 = 1'b0;
        wait_done(0, 10);
        check("lit_sub_result", 0, 32'(res_w[0]), 32'd42);
        check("lit_sub_done1", 0, 32'(done1_w[0]), 32'h1);
        wait_idle(40);

        // Both requesters held after a fresh reset: grants alternate starting with 0.
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        req0 = 1'b1; a0 = 8'd2; b0 = 8'd4; op0 = 7'b1000000;
        req1 = 1'b1; a1 = 8'd7; b1 = 8'd2; op1 = 7'b1000000;
        for (int j = 0; j < 3; j++) begin
            wait_done(0, 10);
            check("lit_rr_grant", j, 32'(grant_w[0]), 32'(exp_g[j]));
            check("lit_rr_result", j, 32'(res_w[0]), 32'(exp_r[j]));
        end
        step();
        req0 = 1'b0; req1 = 1'b0;
        wait_idle(40);

        // Malformed opcodes (two bits, then zero) complete at once with err.
        step();
        req1 = 1'b1; a1 = 8'd5; b1 = 8'd5; op1 = 7'b0000011;
        step();
        req1 = 1'b0;
        check("lit_bad_done1", 0, 32'(done1_w[0]), 32'h1);
        check("lit_bad_err", 0, 32'(err_w[0]), 32'h1);
        check("lit_bad_result", 0, 32'(res_w[0]), 32'h0);
        check("lit_bad_state", 0, 32'(cs_w[0]), 32'h3);
        wait_idle(40);
        step();
        req0 = 1'b1; op0 = 7'b0000000;
        step();
        req0 = 1'b0;
        check("lit_zero_err", 0, 32'(err_w[0]), 32'h1);
        wait_idle(40);

        // Enable low blocks grants; dropping it mid-operation lets the operation finish.
        step();
        on = 1'b0; req0 = 1'b1; a0 = 8'd1; b0 = 8'd1; op0 = 7'b1000000;
        step(); step(); step();
        check("lit_off_state", 0, 32'(cs_w[0]), 32'h0);
        check("lit_off_grant", 0, 32'(grant_w[0]), 32'h0);
        on = 1'b1;
        step();
        check("lit_on_grant", 0, 32'(grant_w[0]), 32'h1);
        step();
        check("lit_on_exec", 0, 32'(cs_w[0]), 32'h2);
        on = 1'b0; req0 = 1'b0;
        wait_done(0, 10);
        check("lit_on_result", 0, 32'(res_w[0]), 32'd2);
        wait_idle(40);
        on = 1'b1;

        // Reset during EXEC of the LAT=3 instance aborts without a done pulse.
        step();
        req0 = 1'b1; a0 = 8'd10; b0 = 8'd20; op0 = 7'b1000000;
        step();
        req0 = 1'b0;
        step(); step();
        check("lit_abort_pre", 1, 32'(cs_w[1]), 32'h2);
        rst = 1'b1;
        step();
        check("lit_abort_state", 1, 32'(cs_w[1]), 32'h0);
        check("lit_abort_done", 1, 32'(done0_w[1]), 32'h0);
        check("lit_abort_result", 1, 32'(res_w[1]), 32'h0);
        check("lit_abort_insel", 1, 32'(in_sel_w[1]), 32'h1);
        rst = 1'b0;
        step();
        check("lit_release_insel", 1, 32'(in_sel_w[1]), 32'h4);
        wait_idle(40);
        step(); step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
